prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the CPU instruction store. Receives a framed byte stream and writes 16-bit instruction words (opcode byte high, operand byte low) into program memory at incrementing addresses from 0.
- Holds the CPU off while a load is in progress and until a load completes cleanly.
- Sits between a byte-stream source (UART receiver or test host) and the write port of the program RAM that the CPU fetch path reads.

Parameters:
ADDR_W, 8, program memory address width; max program length 2**ADDR_W words.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  single-cycle request to begin a load; honoured only in IDLE.
abort  input  1  cancel the load in progress.
byte_valid  input  1  byte_data holds a valid byte.
byte_data  input  8  stream byte.
byte_ready  output  1  loader accepts a byte this cycle. Transfer occurs when byte_valid && byte_ready.
wr_en  output  1  program memory write strobe, one cycle per word.
wr_addr  output  ADDR_W  write address.
wr_data  output  16  instruction word {hi, lo}.
cpu_hold  output  1  CPU must stall/stay in reset while high.
busy  output  1  load in progress.
done  output  1  one-cycle pulse at the end of a load.
err  output  1  last load failed (checksum or abort); sticky until next start.
word_count  output  ADDR_W+1  words written in current/last load.

Behaviour:
- Reset (async, any state): state=IDLE. byte_ready, wr_en, busy, done, err, cpu_hold = 0. wr_addr, wr_data, word_count = 0. Internal length and checksum registers = 0.
- Frame format: L, then 2*N data bytes, then C.
  - L is the word count N; L=0 means 2**ADDR_W words.
  - Data bytes arrive high byte first for each word.
  - C is chosen so that (L + all data bytes + C) mod 256 == 0.
- States: IDLE, LEN, HI, LO, CSUM.
  - IDLE: byte_ready=0. On start: go to LEN; set busy=1 and cpu_hold=1; clear err, word_count, checksum and address. All take effect the next cycle.
  - LEN: on transfer, latch N, checksum = byte, go to HI.
  - HI: on transfer, latch the high byte, add it to the checksum, go to LO.
  - LO: on transfer, add the byte to the checksum. In the next cycle:
    - wr_en=1 for exactly one cycle;
    - wr_data = {hi, byte};
    - wr_addr = current word index;
    - word_count increments in the same cycle.
    - Then the address increments. If N words are now written, go to CSUM, else go to HI.
  - CSUM: on transfer, evaluate (checksum + byte) mod 256. In the next cycle:
    - done=1 for one cycle, busy=0, state=IDLE;
    - if the sum is 0: err=0 and cpu_hold=0;
    - else: err=1 and cpu_hold stays 1.
- byte_ready = 1 in LEN, HI, LO and CSUM, including the cycle where wr_en is high. This gives back-to-back acceptance: one byte per cycle sustained, no bubbles.
- Latency: last byte of a word accepted at cycle t → wr_en at t+1. Checksum byte accepted at t → done at t+1.
- Address wrap: with N=2**ADDR_W, the final write goes to address 2**ADDR_W−1 and word_count reaches 2**ADDR_W. The address counter does not wrap into further writes.
- abort while busy, highest priority over a same-cycle transfer:
  - next cycle: IDLE, busy=0, err=1, done=1 pulse, cpu_hold stays 1;
  - no wr_en for a word whose LO byte is accepted in the abort cycle.
- abort in IDLE is ignored. start while busy is ignored.
- start and abort in the same cycle in IDLE: start wins.
- Bytes presented in IDLE are not accepted (byte_ready=0) and have no effect.
- Reset mid-load: all outputs return to their reset values immediately. Partial memory contents are left as written.

Test Plan:
- start; stream 03 22 01 23 00 27 00 90 one byte per cycle → wr_en three cycles, (addr, data) = (0,2201), (1,2300), (2,2700); done pulse; err=0; cpu_hold falls; word_count=3.
- Same frame with C=91 → three writes, done, err=1, cpu_hold stays 1. Next start clears err; a good frame then releases cpu_hold.
- Stall test: drop byte_valid randomly between bytes of the first frame → identical writes and final status; no writes while valid is low.
- abort in the same cycle the second LO byte (00) is accepted → only the write (0,2201); done pulse; err=1; busy=0; word_count=1.
- L=00, 512 data bytes, correct C → 256 writes at addresses 0..255; word_count=256; no extra write; done; err=0.
- Assert reset asynchronously between clock edges mid-frame → all outputs 0 immediately. Bytes presented afterwards in IDLE get byte_ready=0 and cause no writes.

Source files
------------

// File: rtl/prog_loader.sv
// Program-memory loader: parses a framed byte stream (length, hi/lo data pairs,
// checksum) into 16-bit instruction writes and gates the CPU until a clean load.
module prog_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned    LEN_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_HI, S_LO, S_CSUM} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W:0]   r_len, w_len_nxt;
  logic [7:0]        r_csum, w_csum_nxt;
  logic [7:0]        r_hi, w_hi_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [15:0]       r_wr_data, w_wr_data_nxt;
  logic              r_cpu_hold, w_cpu_hold_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [ADDR_W:0]   r_word_count, w_word_count_nxt;

  logic              w_xfer;
  logic [7:0]        w_sum;
  logic [ADDR_W:0]   w_len_in;
  logic [ADDR_W:0]   w_wc_inc;

  assign w_xfer   = byte_valid && (r_state != S_IDLE);
  assign w_sum    = r_csum + byte_data;
  assign w_len_in = (byte_data == 8'd0) ? FULL : LEN_W'(byte_data);
  assign w_wc_inc = r_word_count + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_len_nxt        = r_len;
    w_csum_nxt       = r_csum;
    w_hi_nxt         = r_hi;
    w_wr_en_nxt      = 1'b0;
    w_wr_addr_nxt    = r_wr_addr;
    w_wr_data_nxt    = r_wr_data;
    w_cpu_hold_nxt   = r_cpu_hold;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_err_nxt        = r_err;
    w_word_count_nxt = r_word_count;

    if (r_state == S_IDLE) begin
      if (start) begin
        w_state_nxt      = S_LEN;
        w_busy_nxt       = 1'b1;
        w_cpu_hold_nxt   = 1'b1;
        w_err_nxt        = 1'b0;
        w_word_count_nxt = '0;
        w_csum_nxt       = '0;
        w_wr_addr_nxt    = '0;
      end
    end else if (abort) begin
      // Abort outranks a same-cycle transfer, so a pending LO byte never writes.
      w_state_nxt = S_IDLE;
      w_busy_nxt  = 1'b0;
      w_err_nxt   = 1'b1;
      w_done_nxt  = 1'b1;
    end else if (w_xfer) begin
      unique case (r_state)
        S_LEN: begin
          w_len_nxt   = w_len_in;
          w_csum_nxt  = byte_data;
          w_state_nxt = S_HI;
        end
        S_HI: begin
          w_hi_nxt    = byte_data;
          w_csum_nxt  = w_sum;
          w_state_nxt = S_LO;
        end
        S_LO: begin
          w_csum_nxt       = w_sum;
          w_wr_en_nxt      = 1'b1;
          w_wr_data_nxt    = {r_hi, byte_data};
          w_wr_addr_nxt    = r_word_count[ADDR_W-1:0];
          w_word_count_nxt = w_wc_inc;
          w_state_nxt      = (w_wc_inc == r_len) ? S_CSUM : S_HI;
        end
        S_CSUM: begin
          w_state_nxt    = S_IDLE;
          w_busy_nxt     = 1'b0;
          w_done_nxt     = 1'b1;
          w_err_nxt      = (w_sum != 8'd0);
          w_cpu_hold_nxt = (w_sum != 8'd0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_len        <= '0;
      r_csum       <= '0;
      r_hi         <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_cpu_hold   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_len        <= w_len_nxt;
      r_csum       <= w_csum_nxt;
      r_hi         <= w_hi_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_cpu_hold   <= w_cpu_hold_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_word_count <= w_word_count_nxt;
    end
  end

  assign byte_ready = (r_state != S_IDLE);
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cpu_hold   = r_cpu_hold;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad frames, stalls, abort, full-length
// load and asynchronous reset, with writes logged by a negedge monitor.
module tb_prog_loader;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset, start, abort, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, wr_en, cpu_hold, busy, done, err;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [AW:0]   word_count;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  int stray_wr = 0;
  logic prev_xfer = 1'b0;
  logic [AW+15:0] wq[$];

  logic [7:0]     fa[8] = '{8'h03, 8'h22, 8'h01, 8'h23, 8'h00, 8'h27, 8'h00, 8'h90};
  logic [AW+15:0] ea[3] = '{24'h002201, 24'h012300, 24'h022700};

  prog_loader #(.ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clock = ~clock;

  // A write is legal only in the cycle after an accepted byte.
  always @(negedge clock) begin
    if (wr_en) begin
      wq.push_back({wr_addr, wr_data});
      if (!prev_xfer) stray_wr++;
    end
    if (done) done_cnt++;
    prev_xfer = byte_valid && byte_ready;
    if (prev_xfer) xfer_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
    byte_data  = 8'hEE;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] c, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      put((i == 7) ? c : fa[i]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) tick();
    total++;
    if ({byte_ready, wr_en, busy, done, err, cpu_hold} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000", {byte_ready, wr_en, busy, done, err, cpu_hold});
    end
    total++;
    if ({wr_addr, wr_data, word_count} !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%0d exp=0/0/0", wr_addr, wr_data, word_count);
    end
    #3 reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int k = 0;
    wq.delete(); done_cnt = 0;
    pulse_start();
    total++;
    if ({busy, cpu_hold, byte_ready, err} !== 4'b1110) begin
      bad++; $display("FAIL basic_start got=%b exp=1110", {busy, cpu_hold, byte_ready, err});
    end
    for (int i = 0; i < 8; i++) begin
      put(fa[i]);
      if (i == 2 || i == 4 || i == 6) begin
        total++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, ea[k]}) begin
          bad++; $display("FAIL basic_write%0d got=%b/%h exp=1/%h", k, wr_en, {wr_addr, wr_data}, ea[k]);
        end
        k++;
      end
    end
    total++;
    if ({done, busy, err, cpu_hold} !== 4'b1000) begin
      bad++; $display("FAIL basic_status got=%b exp=1000", {done, busy, err, cpu_hold});
    end
    total++;
    if (word_count !== 9'd3) begin
      bad++; $display("FAIL basic_wcount got=%0d exp=3", word_count);
    end
    tick();
    total++;
    if ({done, wq.size() == 3, done_cnt == 1} !== 3'b011) begin
      bad++; $display("FAIL basic_pulse done=%b writes=%0d dones=%0d exp=0/3/1", done, wq.size(), done_cnt);
    end
  endtask

  task automatic test_bad_csum();
    wq.delete();
    pulse_start();
    send_a(8'h91, 1'b0);
    total++;
    if ({done, busy, err, cpu_hold} !== 4'b1011) begin
      bad++; $display("FAIL badcs_status got=%b exp=1011", {done, busy, err, cpu_hold});
    end
    total++;
    if (wq.size() != 3 || wq[2] !== ea[2]) begin
      bad++; $display("FAIL badcs_writes got=%0d exp=3", wq.size());
    end
    tick();
    pulse_start();
    total++;
    if ({busy, err, cpu_hold} !== 3'b101) begin
      bad++; $display("FAIL badcs_restart got=%b exp=101", {busy, err, cpu_hold});
    end
    send_a(8'h90, 1'b0);
    total++;
    if ({done, err, cpu_hold} !== 3'b100) begin
      bad++; $display("FAIL badcs_recover got=%b exp=100", {done, err, cpu_hold});
    end
    tick();
  endtask

  task automatic test_stall();
    wq.delete(); stray_wr = 0;
    pulse_start();
    send_a(8'h90, 1'b1);
    total++;
    if ({done, err, cpu_hold, word_count} !== {3'b100, 9'd3}) begin
      bad++; $display("FAIL stall_status got=%b/%0d exp=100/3", {done, err, cpu_hold}, word_count);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wq.size() <= i || wq[i] !== ea[i]) begin
        bad++; $display("FAIL stall_write%0d size=%0d exp=%h", i, wq.size(), ea[i]);
      end
    end
    total++;
    if (stray_wr !== 0) begin
      bad++; $display("FAIL stall_stray got=%0d exp=0", stray_wr);
    end
    tick();
  endtask

  task automatic test_abort();
    wq.delete(); done_cnt = 0;
    pulse_start();
    for (int i = 0; i < 4; i++) put(fa[i]);
    byte_valid = 1'b1; byte_data = 8'h00; abort = 1'b1;
    tick();
    byte_valid = 1'b0; abort = 1'b0;
    total++;
    if ({wr_en, done, busy, err, cpu_hold} !== 5'b01011) begin
      bad++; $display("FAIL abort_status got=%b exp=01011", {wr_en, done, busy, err, cpu_hold});
    end
    total++;
    if (word_count !== 9'd1) begin
      bad++; $display("FAIL abort_wcount got=%0d exp=1", word_count);
    end
    repeat (2) tick();
    total++;
    if (wq.size() != 1 || wq[0] !== ea[0] || done_cnt != 1) begin
      bad++; $display("FAIL abort_writes got=%0d dones=%0d exp=1/1", wq.size(), done_cnt);
    end
  endtask

  task automatic test_start_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({done, busy, err} !== 3'b001) begin
      bad++; $display("FAIL idle_abort got=%b exp=001", {done, busy, err});
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total++;
    if ({done, busy, err, byte_ready} !== 4'b0101) begin
      bad++; $display("FAIL start_wins got=%b exp=0101", {done, busy, err, byte_ready});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({done, busy, err, cpu_hold} !== 4'b1011) begin
      bad++; $display("FAIL busy_abort got=%b exp=1011", {done, busy, err, cpu_hold});
    end
    tick();
  endtask

  task automatic test_full();
    logic [7:0] sum = 8'h00;
    logic [7:0] h, l;
    wq.delete();
    pulse_start();
    put(8'h00);
    for (int i = 0; i < 256; i++) begin
      h = 8'(i);
      l = h ^ 8'h5A;
      put(h);
      put(l);
      sum = sum + h + l;
    end
    put(8'h00 - sum);
    total++;
    if ({done, err, cpu_hold, word_count} !== {3'b100, 9'd256}) begin
      bad++; $display("FAIL full_status got=%b/%0d exp=100/256", {done, err, cpu_hold}, word_count);
    end
    repeat (3) tick();
    total++;
    if (wq.size() != 256) begin
      bad++; $display("FAIL full_count got=%0d exp=256", wq.size());
    end
    for (int i = 0; i < 256 && i < wq.size(); i++) begin
      h = 8'(i);
      l = h ^ 8'h5A;
      total++;
      if (wq[i] !== {h, h, l}) begin
        bad++; $display("FAIL full_write%0d got=%h exp=%h", i, wq[i], {h, h, l});
      end
    end
  endtask

  task automatic test_async_reset();
    int n_wr, n_xf;
    wq.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) put(fa[i]);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({byte_ready, wr_en, busy, done, err, cpu_hold} !== 6'b0) begin
      bad++; $display("FAIL areset_flags got=%b exp=000000", {byte_ready, wr_en, busy, done, err, cpu_hold});
    end
    total++;
    if ({wr_addr, wr_data, word_count} !== '0) begin
      bad++; $display("FAIL areset_data got=%h/%h/%0d exp=0/0/0", wr_addr, wr_data, word_count);
    end
    #2 reset = 1'b0;
    tick();
    n_wr = wq.size(); n_xf = xfer_cnt;
    byte_valid = 1'b1; byte_data = 8'h03;
    repeat (4) tick();
    total++;
    if (byte_ready !== 1'b0) begin
      bad++; $display("FAIL idle_ready got=%b exp=0", byte_ready);
    end
    byte_valid = 1'b0;
    repeat (2) tick();
    total++;
    if (wq.size() != n_wr || xfer_cnt != n_xf || busy !== 1'b0) begin
      bad++; $display("FAIL idle_bytes writes=%0d xfers=%0d exp=%0d/%0d", wq.size(), xfer_cnt, n_wr, n_xf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_stall();
    test_abort();
    test_start_abort();
    test_full();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
